bsg_axil_txs: RTL and testbench



---
 rtl/bsg_axil_txs_if.sv | 32 +++
 rtl/bsg_axil_txs.sv | 236 +++++++++++++++++++++++
 tb/tb_bsg_axil_txs.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_axil_txs_if.sv
// ---------------------------------------------------------------------------
// bsg_axil_txs_if
//
// AXI4-Lite write channels (AW, W, B) used by bsg_axil_txs.
//   awaddr/awvalid/awready : write address channel
//   wdata/wstrb/wvalid/wready : write data channel
//   bresp/bvalid/bready    : write response channel
// The master modport drives requests and takes responses; the slave modport
// is the opposite view.
// ---------------------------------------------------------------------------
interface bsg_axil_txs_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/bsg_axil_txs.sv
// ---------------------------------------------------------------------------
// bsg_axil_txs
//
// AXI4-Lite write slave (host-to-manycore). A write to the transmit data
// register (TDR) of slot k pushes the write data into TX FIFO k; any other
// in-range write goes to the slot/monitor register file as a one-cycle
// strobe; everything else answers DECERR. One outstanding write at a time,
// exactly one B response per accepted write.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   axil (slave modport)    AXI4-Lite AW/W/B channels
//   txs_o / txs_v_o         per-FIFO push data / push valid (one-hot or zero)
//   txs_ready_i             per-FIFO ready
//   reg_wr_*_o              register-file write strobe, address, data, strobes
//   drop_cnt_o              number of pushes dropped on timeout
//
// Optional feature: define BSG_AXIL_TXS_TIMEOUT_EN to abandon a push that has
// not been accepted within timeout_p cycles (answered with SLVERR and counted
// in drop_cnt_o). Without it a push waits forever and drop_cnt_o is 0.
//
// num_fifos_p has no meaningful default and should always be overridden.
// ---------------------------------------------------------------------------
module bsg_axil_txs #(
    parameter int          num_fifos_p  = 2,
    parameter logic [31:0] base_addr_p  = 32'h1000,
    parameter int          slot_width_p = 8,
    parameter logic [7:0]  tdr_ofs_p    = 8'h10,
    parameter int          timeout_p    = 1024
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bsg_axil_txs_if.slave                axil,
    output logic [num_fifos_p-1:0][31:0] txs_o,
    output logic [num_fifos_p-1:0]       txs_v_o,
    input  logic [num_fifos_p-1:0]       txs_ready_i,
    output logic                         reg_wr_v_o,
    output logic [31:0]                  reg_wr_addr_o,
    output logic [31:0]                  reg_wr_data_o,
    output logic [3:0]                   reg_wr_strb_o,
    output logic [15:0]                  drop_cnt_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Slots 0..num_fifos_p (the last one being the monitor slot).
    localparam logic [31:0] span_lp     = 32'(num_fifos_p + 1) << slot_width_p;
    localparam logic [31:0] ofs_mask_lp = (32'd1 << slot_width_p) - 32'd1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q, state_d;
    logic        aw_v_q, aw_v_d;
    logic        w_v_q, w_v_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] aw_q, aw_d;
    logic [31:0] w_q, w_d;
    logic [3:0]  strb_q, strb_d;

    logic        reg_wr_v;
    logic        push_v;
    logic        sel_ready;
    logic        tmo_expire;

    // Decode of the captured address; only meaningful in EXEC.
    logic [31:0] rel_addr;
    logic [31:0] slot_idx;
    logic        in_range;
    logic        tdr_hit;
    logic        reg_hit;
    logic        full_strb;

    assign rel_addr  = aw_q - base_addr_p;
    assign slot_idx  = rel_addr >> slot_width_p;
    assign in_range  = (aw_q >= base_addr_p) && (rel_addr < span_lp);
    assign tdr_hit   = in_range && (slot_idx < 32'(num_fifos_p))
                       && ((rel_addr & ofs_mask_lp) == 32'(tdr_ofs_p));
    assign reg_hit   = in_range && !tdr_hit;
    assign full_strb = (strb_q == 4'hF);

    // A push is offered for the whole EXEC stay of a full-word TDR write, so
    // valid and data stay put until the FIFO takes them.
    assign push_v = (state_q == EXEC) && tdr_hit && full_strb;

    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < num_fifos_p; k++) begin
            txs_v_o[k] = push_v && (slot_idx == 32'(k));
            txs_o[k]   = txs_v_o[k] ? w_q : 32'd0;
            if (slot_idx == 32'(k)) begin
                sel_ready = txs_ready_i[k];
            end
        end
    end

`ifdef BSG_AXIL_TXS_TIMEOUT_EN
    localparam int tmo_w_lp = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;

    logic [tmo_w_lp-1:0] tmo_q;
    logic [15:0]         drop_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Expiry only when ready is absent in the last allowed cycle; a
    // handshake in that same cycle still completes the push.
    assign tmo_expire = push_v && !sel_ready
                        && (tmo_q == tmo_w_lp'(timeout_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            tmo_q <= push_v ? tmo_q + 1'b1 : '0;
            if (tmo_expire) begin
                drop_cnt_q <= sat_inc16(drop_cnt_q);
            end
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign tmo_expire = 1'b0;
    assign drop_cnt_o = 16'd0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            aw_v_q   <= 1'b0;
            w_v_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            aw_v_q   <= aw_v_d;
            w_v_q    <= w_v_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    // Payload registers carry no reset; every output that exposes them is
    // gated by a control condition that is cleared by reset.
    always_ff @(posedge clk_i) begin
        aw_q   <= aw_d;
        w_q    <= w_d;
        strb_q <= strb_d;
    end

    always_comb begin
        state_d  = state_q;
        aw_v_d   = aw_v_q;
        w_v_d    = w_v_q;
        aw_d     = aw_q;
        w_d      = w_q;
        strb_d   = strb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        reg_wr_v = 1'b0;

        case (state_q)
            IDLE: begin
                // AW and W are taken independently, in any order.
                if (axil.awvalid && !aw_v_q) begin
                    aw_v_d = 1'b1;
                    aw_d   = axil.awaddr;
                end
                if (axil.wvalid && !w_v_q) begin
                    w_v_d  = 1'b1;
                    w_d    = axil.wdata;
                    strb_d = axil.wstrb;
                end
                if (aw_v_d && w_v_d) begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (tdr_hit) begin
                    if (!full_strb) begin
                        state_d  = RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else if (sel_ready) begin
                        state_d  = RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else if (tmo_expire) begin
                        state_d  = RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end
                end else if (reg_hit) begin
                    reg_wr_v = 1'b1;
                    state_d  = RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                end else begin
                    state_d  = RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_DECERR;
                end
            end

            RESP: begin
                if (axil.bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                    aw_v_d   = 1'b0;
                    w_v_d    = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign axil.awready = (state_q == IDLE) && !aw_v_q;
    assign axil.wready  = (state_q == IDLE) && !w_v_q;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = bresp_q;

    assign reg_wr_v_o    = reg_wr_v;
    assign reg_wr_addr_o = reg_wr_v ? aw_q : 32'd0;
    assign reg_wr_data_o = reg_wr_v ? w_q : 32'd0;
    assign reg_wr_strb_o = reg_wr_v ? strb_q : 4'd0;

endmodule

// File: tb/tb_bsg_axil_txs.sv
// ---------------------------------------------------------------------------
// tb_bsg_axil_txs
//
// Self-checking bench for bsg_axil_txs with two TX FIFO slots. Directed
// writes come from a vector table, random writes are scored against an
// address-map model, and the mid-push reset case is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_bsg_axil_txs;

    localparam int N   = 2;
    localparam int TMO = 4;
`ifdef BSG_AXIL_TXS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int K_NONE = 0;
    localparam int K_PUSH = 1;
    localparam int K_REG  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_axil_txs_if axil ();

    logic [N-1:0][31:0] txs;
    logic [N-1:0]       txs_v;
    logic [N-1:0]       txs_ready;
    logic               reg_wr_v;
    logic [31:0]        reg_wr_addr;
    logic [31:0]        reg_wr_data;
    logic [3:0]         reg_wr_strb;
    logic [15:0]        drop_cnt;

    bsg_axil_txs #(
        .num_fifos_p (N),
        .timeout_p   (TMO)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .axil          (axil),
        .txs_o         (txs),
        .txs_v_o       (txs_v),
        .txs_ready_i   (txs_ready),
        .reg_wr_v_o    (reg_wr_v),
        .reg_wr_addr_o (reg_wr_addr),
        .reg_wr_data_o (reg_wr_data),
        .reg_wr_strb_o (reg_wr_strb),
        .drop_cnt_o    (drop_cnt)
    );

    int checks = 0;
    int errors = 0;
    int drops_exp = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          rdy_dly;
        int          brdy_dly;
        int          kind;
        int          slot;
        logic [1:0]  bresp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address map: slot s spans 0x1000 + s*256 .. +255, s = 0..N (N = monitor).
    function automatic void model(input logic [31:0] addr, input logic [3:0] strb,
                                  output int kind, output int slot, output logic [1:0] bresp);
        longint a;
        longint s;
        longint off;
        a = longint'(addr);
        kind = K_NONE;
        slot = 0;
        bresp = 2'b11;
        if (a >= 64'h1000 && a < 64'h1000 + (N + 1) * 256) begin
            s   = (a - 64'h1000) / 256;
            off = (a - 64'h1000) % 256;
            if (s < N && off == 16) begin
                slot = int'(s);
                if (strb == 4'hF) begin
                    kind  = K_PUSH;
                    bresp = 2'b00;
                end else begin
                    kind  = K_NONE;
                    bresp = 2'b10;
                end
            end else begin
                kind  = K_REG;
                bresp = 2'b00;
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(axil.awready), 32'd1);
        check({tag, "_wready"},  32'(axil.wready),  32'd1);
        check({tag, "_bvalid"},  32'(axil.bvalid),  32'd0);
        check({tag, "_bresp"},   32'(axil.bresp),   32'd0);
        check({tag, "_txs_v"},   32'(txs_v),        32'd0);
        check({tag, "_txs"},     (txs[0] | txs[1]), 32'd0);
        check({tag, "_reg_wr"},  32'(reg_wr_v) | reg_wr_addr | reg_wr_data | 32'(reg_wr_strb), 32'd0);
        check({tag, "_drop"},    32'(drop_cnt),     32'd0);
    endtask

    // Runs one write; called at posedge+1 with the slave idle, returns the same way.
    task automatic run_write(input string tag, input vec_t v);
        int   cyc, vcnt, pushes, regs, bfirst, bwait;
        bit   aw_done, w_done, b_done, aw_hs, w_hs;
        bit   data_ok, onehot_ok, bstable_ok, busy_ok, accept_ok, dropped;
        logic [1:0]   bresp_seen;
        logic [31:0]  r_addr, r_data;
        logic [3:0]   r_strb;
        logic [N-1:0] sel_mask, noise;
        int   exp_vcyc, exp_push, exec_len, exp_bcyc;
        logic [1:0] exp_bresp;

        dropped   = TMO_EN && v.kind == K_PUSH && v.rdy_dly >= TMO;
        exp_vcyc  = (v.kind == K_PUSH) ? (dropped ? TMO : v.rdy_dly + 1) : 0;
        exp_push  = (v.kind == K_PUSH && !dropped) ? 1 : 0;
        exp_bresp = dropped ? 2'b10 : v.bresp;
        exec_len  = (v.kind == K_PUSH) ? exp_vcyc : 1;
        exp_bcyc  = ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1 + exec_len;
        if (dropped && drops_exp < 65535) drops_exp++;
        sel_mask  = (v.kind == K_PUSH) ? (N'(1) << v.slot) : '0;

        cyc = 0; vcnt = 0; pushes = 0; regs = 0; bfirst = -1; bwait = 0;
        aw_done = 0; w_done = 0; b_done = 0;
        data_ok = 1; onehot_ok = 1; bstable_ok = 1; busy_ok = 1; accept_ok = 1;
        bresp_seen = 2'bxx; r_addr = 0; r_data = 0; r_strb = 0;

        while (!b_done && cyc < 300) begin
            axil.awvalid = !aw_done && cyc >= v.aw_dly;
            axil.awaddr  = axil.awvalid ? v.addr : $urandom;
            axil.wvalid  = !w_done && cyc >= v.w_dly;
            axil.wdata   = axil.wvalid ? v.data : $urandom;
            axil.wstrb   = axil.wvalid ? v.strb : 4'($urandom);
            noise        = N'($urandom);
            txs_ready    = ((vcnt >= v.rdy_dly) ? sel_mask : '0) | (noise & ~sel_mask);
            axil.bready  = (bwait >= v.brdy_dly);
            @(negedge clk);
            if (cyc == v.aw_dly && !axil.awready) accept_ok = 0;
            if (cyc == v.w_dly && !axil.wready) accept_ok = 0;
            aw_hs = axil.awvalid && axil.awready;
            w_hs  = axil.wvalid && axil.wready;
            for (int k = 0; k < N; k++) begin
                if (!txs_v[k] && txs[k] !== 32'd0) data_ok = 0;
            end
            if (txs_v != '0) begin
                vcnt++;
                if (txs_v !== sel_mask) onehot_ok = 0;
                else if (txs[v.slot] !== v.data) data_ok = 0;
                if ((txs_v & txs_ready) != '0) pushes++;
            end
            if (reg_wr_v) begin
                regs++;
                r_addr = reg_wr_addr;
                r_data = reg_wr_data;
                r_strb = reg_wr_strb;
            end
            if (axil.bvalid) begin
                if (bfirst < 0) begin
                    bfirst     = cyc;
                    bresp_seen = axil.bresp;
                end else if (axil.bresp !== bresp_seen) begin
                    bstable_ok = 0;
                end
                if (axil.awready || axil.wready) busy_ok = 0;
                if (axil.bready) b_done = 1;
                bwait++;
            end
            @(posedge clk);
            #1;
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.bready  = 1'b0;
        txs_ready    = '0;

        check({tag, "_b_done"},      32'(b_done),      32'd1);
        check({tag, "_bresp"},       32'(bresp_seen),  32'(exp_bresp));
        check({tag, "_bvalid_cyc"},  32'(bfirst),      32'(exp_bcyc));
        check({tag, "_accept"},      32'(accept_ok),   32'd1);
        check({tag, "_valid_cycles"},32'(vcnt),        32'(exp_vcyc));
        check({tag, "_pushes"},      32'(pushes),      32'(exp_push));
        check({tag, "_onehot"},      32'(onehot_ok),   32'd1);
        check({tag, "_push_data"},   32'(data_ok),     32'd1);
        check({tag, "_reg_count"},   32'(regs),        (v.kind == K_REG) ? 32'd1 : 32'd0);
        if (v.kind == K_REG) begin
            check({tag, "_reg_addr"}, r_addr,         v.addr);
            check({tag, "_reg_data"}, r_data,         v.data);
            check({tag, "_reg_strb"}, 32'(r_strb),    32'(v.strb));
        end
        check({tag, "_b_stable"},    32'(bstable_ok),  32'd1);
        check({tag, "_busy_ready"},  32'(busy_ok),     32'd1);
        check({tag, "_drop_cnt"},    32'(drop_cnt),    32'(drops_exp));
    endtask

    vec_t tbl[12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin : main
        vec_t rv;
        int   seen_v;

        //          addr       data          strb  aw w rdy brdy kind    slot bresp
        tbl[0]  = '{32'h1110, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, K_PUSH, 1, 2'b00};
        tbl[1]  = '{32'h1010, 32'h00000005, 4'hF, 2, 0, 5, 0, K_PUSH, 0, 2'b00};
        tbl[2]  = '{32'h1204, 32'h12345678, 4'hF, 0, 0, 0, 0, K_REG,  0, 2'b00};
        tbl[3]  = '{32'h2000, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, K_NONE, 0, 2'b11};
        tbl[4]  = '{32'h1010, 32'hCAFEF00D, 4'h3, 0, 0, 0, 0, K_NONE, 0, 2'b10};
        tbl[5]  = '{32'h1110, 32'hA5A5A5A5, 4'hF, 0, 3, 1, 3, K_PUSH, 1, 2'b00};
        tbl[6]  = '{32'h1014, 32'h11223344, 4'h5, 1, 0, 0, 0, K_REG,  0, 2'b00};
        tbl[7]  = '{32'h1210, 32'h55667788, 4'hF, 0, 0, 0, 1, K_REG,  0, 2'b00};
        tbl[8]  = '{32'h0FFC, 32'h99AABBCC, 4'hF, 0, 1, 0, 0, K_NONE, 0, 2'b11};
        tbl[9]  = '{32'h1300, 32'hDDEEFF00, 4'hF, 0, 0, 0, 0, K_NONE, 0, 2'b11};
        tbl[10] = '{32'h12FF, 32'h0F0F0F0F, 4'h8, 0, 0, 0, 0, K_REG,  0, 2'b00};
        tbl[11] = '{32'h1010, 32'h76543210, 4'hF, 0, 0, 10, 0, K_PUSH, 0, 2'b00};

        axil.awvalid = 1'b0; axil.awaddr = '0;
        axil.wvalid  = 1'b0; axil.wdata  = '0; axil.wstrb = '0;
        axil.bready  = 1'b0;
        txs_ready    = '0;

        // Reset state, then release.
        #1;
        check_reset_outputs("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_write($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the middle of a stalled push: everything returns to reset
        // values at once and the abandoned write never answers.
        axil.awvalid = 1'b1; axil.awaddr = 32'h1010;
        axil.wvalid  = 1'b1; axil.wdata  = 32'hFEEDFACE; axil.wstrb = 4'hF;
        txs_ready    = '0;
        @(posedge clk);
        #1;
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        @(negedge clk);
        check("midrst_pre_push_v", 32'(txs_v), 32'd1);
        check("midrst_pre_push_d", txs[0], 32'hFEEDFACE);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        drops_exp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        axil.bready = 1'b1;
        txs_ready   = '1;
        seen_v = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (axil.bvalid || txs_v != '0 || reg_wr_v) seen_v++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_response", 32'(seen_v), 32'd0);
        axil.bready = 1'b0;
        txs_ready   = '0;
        run_write("post_reset", tbl[0]);

        // Random writes against the address-map model.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7) begin
                rv.addr = 32'h1000 + 32'($urandom_range(0, N + 1)) * 32'd256
                          + (($urandom_range(0, 1) == 1) ? 32'h10 : 32'($urandom_range(0, 255)));
            end else begin
                rv.addr = $urandom;
            end
            rv.data     = $urandom;
            rv.strb     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            rv.aw_dly   = $urandom_range(0, 3);
            rv.w_dly    = $urandom_range(0, 3);
            rv.rdy_dly  = $urandom_range(0, 6);
            rv.brdy_dly = $urandom_range(0, 2);
            model(rv.addr, rv.strb, rv.kind, rv.slot, rv.bresp);
            run_write($sformatf("rnd%0d", i), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
